dds_wave_core: RTL and testbench
================================

Name: dds_wave_core

Overview:
- DDS core running in the Fg_CLK domain produced by the clock divider, directly downstream of it.
- Phase accumulator driven by a frequency tuning word (FTW); generates sine, square, triangle or sawtooth samples, scales them by amplitude, and presents offset-binary words for the DAC interface.
- Waveform and amplitude changes are phase-synchronous, so there is no mid-period glitch.

Parameters:
- PHASE_W, 32, accumulator and FTW width.
- LUT_AW, 8, quarter-wave sine LUT address width (2^LUT_AW entries).
- DAC_W, 12, output sample width.

Ports:
- Fg_CLK  in  1  core clock, the Fg_CLK output of the clock divider.
- Fg_RESETn  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low.
- Enable  in  1  run the accumulator and sample pipeline.
- Ftw_In  in  PHASE_W  frequency tuning word.
- Ftw_Load  in  1  one-cycle strobe; captures Ftw_In.
- Wave_Sel  in  2  0=sine, 1=square, 2=triangle, 3=sawtooth (shadowed).
- Amp  in  8  amplitude 0..255, gain Amp/256 (shadowed).
- Dac_Data  out  DAC_W  offset-binary sample.
- Dac_Valid  out  1  Dac_Data carries a live sample.
- Phase_Sync  out  1  one-cycle pulse when the accumulator wraps.

Behaviour:
- Reset (sampled on the Fg_CLK edge when Fg_RESETn=0) clears the following:
  - acc=0, ftw_reg=0, wave_act=0, amp_act=0, all pipeline registers and valid bits.
  - Dac_Data=MID (2^(DAC_W-1), 0x800), Dac_Valid=0, Phase_Sync=0.
  - Reset mid-operation takes effect on that edge with no drain.
- Ftw_Load=1: ftw_reg<=Ftw_In whatever the Enable state. The new value is used in the next accumulation.
- Enable=1: acc<=acc+ftw_reg mod 2^PHASE_W. On carry-out, Phase_Sync=1 for the cycle acc holds the wrapped value.
- Enable=0: acc holds and Phase_Sync=0.
- Shadow loading: wave_act<=Wave_Sel and amp_act<=Amp on the same edge as a wrapping accumulation, or on any edge while Enable=0. Otherwise they hold.
- Pipeline: latency is 4. The sample for acc value A appears on Dac_Data 4 cycles after acc holds A.
  - S1: register t=acc[MSB -: DAC_W], quadrant=acc top 2 bits, LUT address, wave_act, amp_act, valid.
  - S2: LUT read (synchronous ROM), aux data delayed.
  - S3: select the signed sample s and register s*amp.
  - S4: Dac_Data=(product>>>8)+MID.
  - Valid bit per stage = Enable at acc stage. Dac_Valid=S4 valid.
  - When S4 valid=0, Dac_Data=MID.
- Signed sample s (DAC_W bits, max M=2^(DAC_W-1)-1):
  - Sine: quadrants 1 and 3 use the mirrored address (~addr); quadrants 2 and 3 negate the magnitude.
  - Square: +M if t MSB=0, else -M.
  - Triangle: u=t[DAC_W-2:0]; tri=(MSB ? ~u : u)<<1; s=tri-2^(DAC_W-1).
  - Sawtooth: s=t with MSB inverted.
- Scaling: signed product, arithmetic shift right by 8 (floor). Amp=0 gives MID.
- Simultaneous Ftw_Load and wrap: both take effect, with no priority conflict.

Decomposition:
- dds_pkg holds:
  - WAVE_SINE/SQUARE/TRI/SAW codes.
  - Default widths.
  - MID and M constants, derived as functions of DAC_W.
- Sub-module dds_sine_lut: quarter-wave synchronous ROM with 1-cycle latency.
  - Entry k=round(M*sin(pi/2*(k+0.5)/2^LUT_AW)), unsigned DAC_W-1 bits.

Test Plan:
- Reset with Enable=0 -> Dac_Data=0x800, Dac_Valid=0, Phase_Sync=0. Outputs hold for 20 cycles after release.
- FTW=0x4000_0000, saw, Amp=255, Enable=1 -> Dac_Valid rises 4 cycles after the first acc update. Dac_Data repeats 0x008,0x404,0x800,0xBFC. Phase_Sync pulses every 4 cycles.
- FTW=0x2000_0000, square, Amp=128 -> 4 samples 0xBFF, then 4 samples 0x400, repeating.
- Saw running, Wave_Sel switched to square mid-period -> output stays sawtooth until the sample whose acc coincides with the next Phase_Sync, then switches to square.
- Sine, FTW=0x0100_0000, Amp=255 -> Dac_Data(p)+Dac_Data(p+0x8000_0000) is 4095 or 4096 for all p. Samples are mirror-symmetric within each half-period. Peak is at most 0xFF7.
- Enable dropped mid-run -> acc frozen. Dac_Valid falls 4 cycles later with Dac_Data=0x800. Fg_RESETn pulsed mid-run -> all outputs are at reset values on the next edge.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared constants and helpers for the DDS waveform core: wave codes,
// default widths, DAC midscale/peak values and the sine table generator.
package dds_pkg;

   localparam int PHASE_W_DEF = 32;
   localparam int LUT_AW_DEF  = 8;
   localparam int DAC_W_DEF   = 12;

   localparam logic [1:0] WAVE_SINE   = 2'd0;
   localparam logic [1:0] WAVE_SQUARE = 2'd1;
   localparam logic [1:0] WAVE_TRI    = 2'd2;
   localparam logic [1:0] WAVE_SAW    = 2'd3;

   // Offset-binary midscale (zero level) for a DAC of the given width.
   function automatic int mid_val(input int dac_w);
      return 1 << (dac_w - 1);
   endfunction

   // Largest positive signed sample for a DAC of the given width.
   function automatic int max_val(input int dac_w);
      return (1 << (dac_w - 1)) - 1;
   endfunction

   // Quarter-wave sine entry k, sampled at the centre of its bin so that the
   // mirrored quadrants line up exactly. Taylor series keeps this usable as a
   // constant function at elaboration time.
   function automatic int sine_entry(input int k, input int lut_aw, input int dac_w);
      real x;
      real term;
      real sum;
      x    = 1.5707963267948966 * (real'(k) + 0.5) / real'(1 << lut_aw);
      term = x;
      sum  = x;
      for (int n = 1; n < 10; n++) begin
         term = -term * x * x / real'((2 * n) * (2 * n + 1));
         sum  = sum + term;
      end
      return $rtoi(real'(max_val(dac_w)) * sum + 0.5);
   endfunction

endpackage

// File: rtl/dds_sine_lut.sv
// Quarter-wave sine ROM with one cycle of read latency. Entries hold the
// unsigned magnitude; quadrant folding and sign are handled by the caller.
module dds_sine_lut
   import dds_pkg::*;
#(
   parameter int LUT_AW = LUT_AW_DEF,
   parameter int DAC_W  = DAC_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [LUT_AW-1:0] addr,
   output logic [DAC_W-2:0]  data
);

   logic [DAC_W-2:0] rom [0:(1 << LUT_AW) - 1];

   generate
      for (genvar gi = 0; gi < (1 << LUT_AW); gi++) begin : g_rom
         localparam int ENTRY = sine_entry(gi, LUT_AW, DAC_W);
         assign rom[gi] = ENTRY[DAC_W-2:0];
      end
   endgenerate

   // Registered ROM read; cleared with the rest of the sample pipeline.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data <= '0;
      end else begin
         data <= rom[addr];
      end
   end

endmodule

// File: rtl/dds_wave_core.sv
// DDS waveform core: phase accumulator, phase-synchronous wave/amplitude
// shadow registers and a 4-stage sample pipeline producing offset-binary
// DAC words.
module dds_wave_core
   import dds_pkg::*;
#(
   parameter int PHASE_W = PHASE_W_DEF,
   parameter int LUT_AW  = LUT_AW_DEF,
   parameter int DAC_W   = DAC_W_DEF
) (
   input  logic               Fg_CLK,
   input  logic               Fg_RESETn,
   input  logic               Enable,
   input  logic [PHASE_W-1:0] Ftw_In,
   input  logic               Ftw_Load,
   input  logic [1:0]         Wave_Sel,
   input  logic [7:0]         Amp,
   output logic [DAC_W-1:0]   Dac_Data,
   output logic               Dac_Valid,
   output logic               Phase_Sync
);

   localparam logic [DAC_W-1:0]        MID   = DAC_W'(mid_val(DAC_W));
   localparam logic signed [DAC_W-1:0] M_POS = DAC_W'(max_val(DAC_W));

   // accumulator stage
   logic [PHASE_W-1:0] acc_reg;
   logic [PHASE_W-1:0] ftw_reg;
   logic               acc_valid_reg;
   logic               phase_sync_reg;
   logic [1:0]         wave_act_reg;
   logic [7:0]         amp_act_reg;
   logic [PHASE_W:0]   acc_sum_next;
   logic               wrap_next;

   // S1
   logic [DAC_W-1:0]   t1_reg;
   logic [LUT_AW-1:0]  addr1_reg;
   logic [1:0]         wave1_reg;
   logic [7:0]         amp1_reg;
   logic               v1_reg;
   logic [LUT_AW-1:0]  lut_addr_next;

   // S2
   logic [DAC_W-1:0]   t2_reg;
   logic [1:0]         wave2_reg;
   logic [7:0]         amp2_reg;
   logic               v2_reg;
   logic [DAC_W-2:0]   lut_data;

   // S3
   logic signed [DAC_W-1:0]   mag_ext;
   logic [DAC_W-1:0]          tri_next;
   logic signed [DAC_W-1:0]   sample_next;
   logic signed [DAC_W+7:0]   prod_next;
   logic signed [DAC_W+7:0]   prod3_reg;
   logic                      v3_reg;

   // S4
   logic [DAC_W-1:0]   dac_data_reg;
   logic               dac_valid_reg;

   assign acc_sum_next = {1'b0, acc_reg} + {1'b0, ftw_reg};
   assign wrap_next    = Enable & acc_sum_next[PHASE_W];

   // Phase accumulation, FTW capture and phase-aligned shadow loading.
   always_ff @(posedge Fg_CLK) begin
      if (!Fg_RESETn) begin
         acc_reg        <= '0;
         ftw_reg        <= '0;
         acc_valid_reg  <= 1'b0;
         phase_sync_reg <= 1'b0;
         wave_act_reg   <= WAVE_SINE;
         amp_act_reg    <= '0;
      end else begin
         if (Ftw_Load) begin
            ftw_reg <= Ftw_In;
         end
         if (Enable) begin
            acc_reg <= acc_sum_next[PHASE_W-1:0];
         end
         acc_valid_reg  <= Enable;
         phase_sync_reg <= wrap_next;
         if (wrap_next || !Enable) begin
            wave_act_reg <= Wave_Sel;
            amp_act_reg  <= Amp;
         end
      end
   end

   // Quadrants 1 and 3 walk the quarter-wave table backwards.
   assign lut_addr_next = acc_reg[PHASE_W-2] ? ~acc_reg[PHASE_W-3 -: LUT_AW]
                                             :  acc_reg[PHASE_W-3 -: LUT_AW];

   // S1: capture phase slice, table address and the active wave settings.
   always_ff @(posedge Fg_CLK) begin
      if (!Fg_RESETn) begin
         t1_reg    <= '0;
         addr1_reg <= '0;
         wave1_reg <= WAVE_SINE;
         amp1_reg  <= '0;
         v1_reg    <= 1'b0;
      end else begin
         t1_reg    <= acc_reg[PHASE_W-1 -: DAC_W];
         addr1_reg <= lut_addr_next;
         wave1_reg <= wave_act_reg;
         amp1_reg  <= amp_act_reg;
         v1_reg    <= acc_valid_reg;
      end
   end

   dds_sine_lut #(
      .LUT_AW (LUT_AW),
      .DAC_W  (DAC_W)
   ) u_sine_lut (
      .clk   (Fg_CLK),
      .rst_n (Fg_RESETn),
      .addr  (addr1_reg),
      .data  (lut_data)
   );

   // S2: delay side data alongside the table read.
   always_ff @(posedge Fg_CLK) begin
      if (!Fg_RESETn) begin
         t2_reg    <= '0;
         wave2_reg <= WAVE_SINE;
         amp2_reg  <= '0;
         v2_reg    <= 1'b0;
      end else begin
         t2_reg    <= t1_reg;
         wave2_reg <= wave1_reg;
         amp2_reg  <= amp1_reg;
         v2_reg    <= v1_reg;
      end
   end

   assign mag_ext = $signed({1'b0, lut_data});

   // Signed sample selection; the phase MSB is also the sine half-cycle sign.
   always_comb begin
      tri_next    = {(t2_reg[DAC_W-1] ? ~t2_reg[DAC_W-2:0] : t2_reg[DAC_W-2:0]), 1'b0};
      sample_next = '0;
      case (wave2_reg)
         WAVE_SINE:   sample_next = t2_reg[DAC_W-1] ? -mag_ext : mag_ext;
         WAVE_SQUARE: sample_next = t2_reg[DAC_W-1] ? -M_POS : M_POS;
         WAVE_TRI:    sample_next = $signed(tri_next - MID);
         default:     sample_next = $signed({~t2_reg[DAC_W-1], t2_reg[DAC_W-2:0]});
      endcase
   end

   // |sample * amp| stays below 2^(DAC_W+7), so DAC_W+8 signed bits suffice.
   assign prod_next = $signed({{8{sample_next[DAC_W-1]}}, sample_next})
                    * $signed({{DAC_W{1'b0}}, amp2_reg});

   // S3: register the scaled product.
   always_ff @(posedge Fg_CLK) begin
      if (!Fg_RESETn) begin
         prod3_reg <= '0;
         v3_reg    <= 1'b0;
      end else begin
         prod3_reg <= prod_next;
         v3_reg    <= v2_reg;
      end
   end

   // S4: floor-divide by 256 and shift to offset binary; idle at midscale.
   always_ff @(posedge Fg_CLK) begin
      if (!Fg_RESETn) begin
         dac_data_reg  <= MID;
         dac_valid_reg <= 1'b0;
      end else begin
         dac_data_reg  <= v3_reg ? DAC_W'(prod3_reg >>> 8) + MID : MID;
         dac_valid_reg <= v3_reg;
      end
   end

   assign Dac_Data   = dac_data_reg;
   assign Dac_Valid  = dac_valid_reg;
   assign Phase_Sync = phase_sync_reg;

endmodule

// File: tb/tb_dds_wave_core.sv
// Self-checking bench for dds_wave_core: directed scenarios plus a random
// run, all checked cycle by cycle against an arithmetic reference model.
module tb_dds_wave_core;

   logic        Fg_CLK = 1'b0;
   logic        Fg_RESETn = 1'b0;
   logic        Enable = 1'b0;
   logic [31:0] Ftw_In = '0;
   logic        Ftw_Load = 1'b0;
   logic [1:0]  Wave_Sel = '0;
   logic [7:0]  Amp = '0;
   logic [11:0] Dac_Data;
   logic        Dac_Valid;
   logic        Phase_Sync;

   dds_wave_core dut (
      .Fg_CLK     (Fg_CLK),
      .Fg_RESETn  (Fg_RESETn),
      .Enable     (Enable),
      .Ftw_In     (Ftw_In),
      .Ftw_Load   (Ftw_Load),
      .Wave_Sel   (Wave_Sel),
      .Amp        (Amp),
      .Dac_Data   (Dac_Data),
      .Dac_Valid  (Dac_Valid),
      .Phase_Sync (Phase_Sync)
   );

   always #5 Fg_CLK = ~Fg_CLK;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input longint obs, input longint exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, wanted 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      bit              v;
      longint unsigned acc;
      int              wave;
      int              amp;
   } tap_t;

   int              lut_tab[256];
   longint unsigned m_acc, m_ftw;
   int              m_wave, m_amp;
   bit              m_accv, m_sync;
   tap_t            dl[4];

   // Sample value for a given phase, wave and amplitude, straight from the
   // waveform definitions.
   function automatic int ref_sample(longint unsigned a, int w, int am);
      int s, q, k, t, u, p, fl;
      t = int'(a >> 20) & 4095;
      case (w)
         0: begin
            q = int'(a >> 30) & 3;
            k = int'(a >> 22) & 255;
            if (q % 2 == 1) k = 255 - k;
            s = lut_tab[k];
            if (q >= 2) s = -s;
         end
         1: s = (t >= 2048) ? -2047 : 2047;
         2: begin
            u = t & 2047;
            if (t >= 2048) u = 2047 - u;
            s = 2 * u - 2048;
         end
         default: s = t - 2048;
      endcase
      p  = s * am;
      fl = (p >= 0) ? p / 256 : -((-p + 255) / 256);
      return fl + 2048;
   endfunction

   task automatic model_edge(input bit rst_n, input bit en, input bit ld,
                             input logic [31:0] fin, input logic [1:0] ws, input logic [7:0] am);
      longint unsigned sum;
      bit wrap;
      tap_t cur;
      if (!rst_n) begin
         m_acc = 0; m_ftw = 0; m_wave = 0; m_amp = 0; m_accv = 0; m_sync = 0;
         for (int i = 0; i < 4; i++) dl[i].v = 0;
      end else begin
         cur.v = m_accv; cur.acc = m_acc; cur.wave = m_wave; cur.amp = m_amp;
         dl[3] = dl[2]; dl[2] = dl[1]; dl[1] = dl[0]; dl[0] = cur;
         sum  = m_acc + m_ftw;
         wrap = en && ((sum >> 32) != 0);
         if (en) m_acc = sum & 64'hFFFF_FFFF;
         m_sync = wrap;
         if (wrap || !en) begin
            m_wave = int'(ws);
            m_amp  = int'(am);
         end
         if (ld) m_ftw = fin;
         m_accv = en;
      end
   endtask

   // One clock: drive inputs, advance the model, then compare all outputs.
   task automatic step(input bit rst_n, input bit en, input bit ld,
                       input logic [31:0] fin, input logic [1:0] ws, input logic [7:0] am);
      int exp_data;
      Fg_RESETn = rst_n; Enable = en; Ftw_Load = ld; Ftw_In = fin; Wave_Sel = ws; Amp = am;
      @(posedge Fg_CLK);
      model_edge(rst_n, en, ld, fin, ws, am);
      #1;
      exp_data = dl[3].v ? ref_sample(dl[3].acc, dl[3].wave, dl[3].amp) : 2048;
      check("dac_data", Dac_Data, exp_data);
      check("dac_valid", Dac_Valid, dl[3].v);
      check("phase_sync", Phase_Sync, m_sync);
   endtask

   int saw_tab[4] = '{12'h404, 12'h800, 12'hBFC, 12'h008};
   int arr[1024];

   // Run the sine wave from reset and record each live sample by phase bin.
   task automatic run_sine(input logic [31:0] ftw, input int nsteps, output int peak);
      int j;
      longint unsigned a;
      for (int i = 0; i < 1024; i++) arr[i] = -1;
      step(0, 0, 0, 0, 2'd0, 8'd255);
      step(1, 0, 1, ftw, 2'd0, 8'd255);
      j = 0;
      peak = 0;
      for (int n = 0; n < nsteps; n++) begin
         step(1, 1, 0, 0, 2'd0, 8'd255);
         if (Dac_Valid) begin
            a = (longint'(j + 1) * longint'(ftw)) & 64'hFFFF_FFFF;
            arr[int'(a >> 22)] = int'(Dac_Data);
            if (int'(Dac_Data) > peak) peak = int'(Dac_Data);
            j++;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, total=%0d", total);
      $fatal(1);
   end

   initial begin
      int first, j, hi, lo, ps_n, ff7_n, viol, peak, fall, fall_data, s;
      for (int k = 0; k < 256; k++)
         lut_tab[k] = $rtoi(2047.0 * $sin(3.141592653589793 / 2.0 * (real'(k) + 0.5) / 256.0) + 0.5);
      for (int i = 0; i < 4; i++) dl[i].v = 0;

      // reset with Enable low, then idle
      step(0, 0, 0, 0, 2'd3, 8'd255);
      step(0, 0, 0, 0, 2'd3, 8'd255);
      check("rst_data", Dac_Data, 12'h800);
      check("rst_valid", Dac_Valid, 0);
      check("rst_sync", Phase_Sync, 0);
      for (int n = 0; n < 20; n++) step(1, 0, 0, 0, 2'd3, 8'd255);
      check("idle_data", Dac_Data, 12'h800);
      $display("[tb] reset/idle done checks=%0d", total);

      // sawtooth, quarter-rate
      step(1, 0, 1, 32'h4000_0000, 2'd3, 8'd255);
      first = 0; j = 0; ps_n = 0;
      for (int n = 1; n <= 24; n++) begin
         step(1, 1, 0, 0, 2'd3, 8'd255);
         if (Dac_Valid && first == 0) first = n;
         if (Dac_Valid) begin
            check("saw_seq", Dac_Data, saw_tab[j % 4]);
            j++;
         end
         if (Phase_Sync) begin
            if (ps_n != 0) check("saw_sync_period", n - ps_n, 4);
            ps_n = n;
         end
      end
      check("saw_latency", first - 1, 4);
      $display("[tb] sawtooth done checks=%0d", total);

      // square, eighth-rate, half amplitude
      step(0, 0, 0, 0, 2'd1, 8'd128);
      step(1, 0, 1, 32'h2000_0000, 2'd1, 8'd128);
      hi = 0; lo = 0; j = 0;
      for (int n = 0; n < 24; n++) begin
         step(1, 1, 0, 0, 2'd1, 8'd128);
         if (Dac_Valid && j < 8) begin
            if (Dac_Data == 12'hBFF) hi++;
            if (Dac_Data == 12'h400) lo++;
            j++;
         end
      end
      check("sq_hi_count", hi, 4);
      check("sq_lo_count", lo, 4);
      $display("[tb] square done checks=%0d", total);

      // saw -> square switch mid-period takes effect at the next wrap
      step(0, 0, 0, 0, 2'd3, 8'd255);
      step(1, 0, 1, 32'h1000_0000, 2'd3, 8'd255);
      ps_n = 0; ff7_n = 0;
      for (int n = 1; n <= 40; n++) begin
         step(1, 1, 0, 0, (n > 10) ? 2'd1 : 2'd3, 8'd255);
         if (n > 10 && Phase_Sync && ps_n == 0) ps_n = n;
         if (Dac_Valid && Dac_Data == 12'hFF7 && ff7_n == 0) ff7_n = n;
      end
      check("switch_sync_at", ps_n, 16);
      check("switch_sample_at", ff7_n - ps_n, 4);
      $display("[tb] wave switch done checks=%0d", total);

      // sine: half-period complement and peak, coarse and fine steps
      run_sine(32'h0100_0000, 300, peak);
      viol = 0;
      for (int p = 0; p < 512; p++)
         if (arr[p] >= 0 && arr[p + 512] >= 0) begin
            s = arr[p] + arr[p + 512];
            if (s != 4095 && s != 4096) viol++;
         end
      check("sine_sum_coarse", viol, 0);
      check("sine_peak_coarse_le", peak <= 12'hFF7, 1);
      run_sine(32'h0040_0000, 1030, peak);
      viol = 0;
      for (int p = 0; p < 512; p++) begin
         s = arr[p] + arr[p + 512];
         if (arr[p] < 0 || (s != 4095 && s != 4096)) viol++;
      end
      check("sine_sum_fine", viol, 0);
      viol = 0;
      for (int p = 0; p < 256; p++) begin
         if (arr[p] != arr[511 - p]) viol++;
         if (arr[512 + p] != arr[1023 - p]) viol++;
      end
      check("sine_mirror", viol, 0);
      check("sine_peak", peak, 12'hFF7);
      $display("[tb] sine done checks=%0d", total);

      // Enable dropped mid-run: valid falls 4 cycles later at midscale
      fall = 0; fall_data = 0;
      for (int n = 1; n <= 10; n++) begin
         step(1, 0, 0, 0, 2'd0, 8'd255);
         if (!Dac_Valid && fall == 0) begin
            fall = n;
            fall_data = int'(Dac_Data);
         end
      end
      check("dis_latency", fall - 1, 4);
      check("dis_data", fall_data, 12'h800);
      for (int n = 0; n < 12; n++) step(1, 1, 0, 0, 2'd0, 8'd255);
      $display("[tb] enable drop done checks=%0d", total);

      // reset pulse mid-run
      step(1, 1, 1, 32'h3000_0000, 2'd2, 8'd200);
      for (int n = 0; n < 12; n++) step(1, 1, 0, 0, 2'd2, 8'd200);
      step(0, 1, 0, 0, 2'd2, 8'd200);
      check("midrst_data", Dac_Data, 12'h800);
      check("midrst_valid", Dac_Valid, 0);
      check("midrst_sync", Phase_Sync, 0);
      $display("[tb] mid-run reset done checks=%0d", total);

      // random traffic
      for (int n = 0; n < 3000; n++)
         step(($urandom % 300) != 0, ($urandom % 8) != 0, ($urandom % 10) == 0,
              $urandom, 2'($urandom), 8'($urandom));
      $display("[tb] random done checks=%0d", total);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
